// File: rtl/velocity_ramp_generator.sv
// Acceleration limiter for body velocity commands: captures vx/vy/wz and slews each
// sign-magnitude output toward its command by at most one step per ramp tick.
module velocity_ramp_generator #(
    parameter int N_WIDTH  = 17,
    parameter int Q_WIDTH  = 8,
    parameter int TICK_DIV = 50000,
    parameter int STEP_V   = 64,
    parameter int STEP_W   = 16
) (
    input  logic               VELOCITY_RAMP_CLOCK_50,
    input  logic               VELOCITY_RAMP_RESET_InLow,
    input  logic [N_WIDTH-1:0] VELOCITY_RAMP_CMDVX_InBus,
    input  logic [N_WIDTH-1:0] VELOCITY_RAMP_CMDVY_InBus,
    input  logic [N_WIDTH-1:0] VELOCITY_RAMP_CMDWZ_InBus,
    input  logic               VELOCITY_RAMP_CMDVALID_InHigh,
    input  logic               VELOCITY_RAMP_STOP_InHigh,
    output logic [N_WIDTH-1:0] VELOCITY_RAMP_TARGETVX_OutBus,
    output logic [N_WIDTH-1:0] VELOCITY_RAMP_TARGETVY_OutBus,
    output logic [N_WIDTH-1:0] VELOCITY_RAMP_TARGETWZ_OutBus,
    output logic               VELOCITY_RAMP_SETTLED_OutHigh,
    output logic               VELOCITY_RAMP_UPDATE_OutHigh
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [N_WIDTH:0]   TC_ONE   = (N_WIDTH+1)'(1);
    localparam logic [N_WIDTH:0]   STEP_V_TC = (N_WIDTH+1)'(STEP_V);
    localparam logic [N_WIDTH:0]   STEP_W_TC = (N_WIDTH+1)'(STEP_W);
    localparam logic [N_WIDTH-1:0] SM_ZERO  = {N_WIDTH{1'b0}};

    if (TICK_DIV < 2 || Q_WIDTH >= N_WIDTH) begin : g_bad_params
        $error("velocity_ramp_generator: invalid TICK_DIV or Q_WIDTH");
    end

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RAMP = 1'b1} state_e;

    function automatic logic [N_WIDTH:0] sm_to_tc(input logic [N_WIDTH-1:0] sm);
        logic [N_WIDTH:0] mag;
        mag = {2'b00, sm[N_WIDTH-2:0]};
        if (sm[N_WIDTH-1]) return ~mag + TC_ONE;
        else               return mag;
    endfunction

    // Zero always comes back as +0 because a zero result has a clear sign bit.
    function automatic logic [N_WIDTH-1:0] tc_to_sm(input logic [N_WIDTH:0] tc);
        logic [N_WIDTH:0]   mag;
        logic [N_WIDTH-1:0] res;
        if (tc[N_WIDTH]) mag = ~tc + TC_ONE;
        else             mag = tc;
        res = N_WIDTH'(mag);
        res[N_WIDTH-1] = tc[N_WIDTH];
        return res;
    endfunction

    function automatic logic [N_WIDTH-1:0] norm_sm(input logic [N_WIDTH-1:0] sm);
        if (sm[N_WIDTH-2:0] == {(N_WIDTH-1){1'b0}}) return SM_ZERO;
        else                                         return sm;
    endfunction

    function automatic logic [N_WIDTH-1:0] step_axis(input logic [N_WIDTH-1:0] out_sm,
                                                     input logic [N_WIDTH-1:0] cmd_sm,
                                                     input logic [N_WIDTH:0]   step);
        logic [N_WIDTH:0] o_tc, c_tc, diff, adiff, res;
        o_tc  = sm_to_tc(out_sm);
        c_tc  = sm_to_tc(cmd_sm);
        diff  = c_tc - o_tc;
        adiff = diff[N_WIDTH] ? (~diff + TC_ONE) : diff;
        if (adiff <= step)     res = c_tc;
        else if (diff[N_WIDTH]) res = o_tc - step;
        else                    res = o_tc + step;
        return tc_to_sm(res);
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_WIDTH-1:0] cmd_vx_q, cmd_vx_d, cmd_vy_q, cmd_vy_d, cmd_wz_q, cmd_wz_d;
    logic [N_WIDTH-1:0] out_vx_q, out_vx_d, out_vy_q, out_vy_d, out_wz_q, out_wz_d;
    logic               update_q, update_d;
    logic               settled_q, settled_d;

    // Next-state logic: command capture, tick counting and per-axis stepping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_vx_d = cmd_vx_q;
        cmd_vy_d = cmd_vy_q;
        cmd_wz_d = cmd_wz_q;
        out_vx_d = out_vx_q;
        out_vy_d = out_vy_q;
        out_wz_d = out_wz_q;
        update_d = 1'b0;

        if (VELOCITY_RAMP_STOP_InHigh) begin
            cmd_vx_d = SM_ZERO;
            cmd_vy_d = SM_ZERO;
            cmd_wz_d = SM_ZERO;
        end else if (VELOCITY_RAMP_CMDVALID_InHigh) begin
            cmd_vx_d = norm_sm(VELOCITY_RAMP_CMDVX_InBus);
            cmd_vy_d = norm_sm(VELOCITY_RAMP_CMDVY_InBus);
            cmd_wz_d = norm_sm(VELOCITY_RAMP_CMDWZ_InBus);
        end else begin
            cmd_vx_d = cmd_vx_q;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (cmd_vx_q != out_vx_q || cmd_vy_q != out_vy_q || cmd_wz_q != out_wz_q)
                    state_d = ST_RAMP;
                else
                    state_d = ST_IDLE;
            end
            ST_RAMP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = {CNT_W{1'b0}};
                    out_vx_d = step_axis(out_vx_q, cmd_vx_q, STEP_V_TC);
                    out_vy_d = step_axis(out_vy_q, cmd_vy_q, STEP_V_TC);
                    out_wz_d = step_axis(out_wz_q, cmd_wz_q, STEP_W_TC);
                    update_d = 1'b1;
                    if (out_vx_d == cmd_vx_q && out_vy_d == cmd_vy_q && out_wz_d == cmd_wz_q)
                        state_d = ST_IDLE;
                    else
                        state_d = ST_RAMP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        settled_d = (state_d == ST_IDLE);
    end

    // State, command and output registers with asynchronous clear.
    always_ff @(posedge VELOCITY_RAMP_CLOCK_50 or negedge VELOCITY_RAMP_RESET_InLow) begin
        if (!VELOCITY_RAMP_RESET_InLow) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            cmd_vx_q  <= SM_ZERO;
            cmd_vy_q  <= SM_ZERO;
            cmd_wz_q  <= SM_ZERO;
            out_vx_q  <= SM_ZERO;
            out_vy_q  <= SM_ZERO;
            out_wz_q  <= SM_ZERO;
            update_q  <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_vx_q  <= cmd_vx_d;
            cmd_vy_q  <= cmd_vy_d;
            cmd_wz_q  <= cmd_wz_d;
            out_vx_q  <= out_vx_d;
            out_vy_q  <= out_vy_d;
            out_wz_q  <= out_wz_d;
            update_q  <= update_d;
            settled_q <= settled_d;
        end
    end

    assign VELOCITY_RAMP_TARGETVX_OutBus = out_vx_q;
    assign VELOCITY_RAMP_TARGETVY_OutBus = out_vy_q;
    assign VELOCITY_RAMP_TARGETWZ_OutBus = out_wz_q;
    assign VELOCITY_RAMP_SETTLED_OutHigh = settled_q;
    assign VELOCITY_RAMP_UPDATE_OutHigh  = update_q;

endmodule

// File: doc/velocity_ramp_generator.md
Name: velocity_ramp_generator

Overview:
- Upstream of the movement controller (wheel inverse kinematics). It produces the TARGETVX/VY/WZ buses that the controller consumes.
- Captures commanded body velocities (vx, vy, wz) and slews each registered output toward its command. Each axis moves by at most a fixed step per tick, which gives acceleration limiting.
- Data format on all buses is N_WIDTH-bit sign-magnitude fixed point: bit N-1 is the sign, the low N-1 bits are the magnitude, and the low Q_WIDTH bits are fractional.

Parameters:
- N_WIDTH, 17: bus width.
- Q_WIDTH, 8: fractional bits.
- TICK_DIV, 50000: clock cycles per ramp tick (1 ms at 50 MHz). Must be >= 2.
- STEP_V, 64: maximum magnitude change of vx/vy per tick, in LSBs (0.25 cm/s).
- STEP_W, 16: maximum magnitude change of wz per tick, in LSBs.

Ports:
- VELOCITY_RAMP_CLOCK_50, in, 1: system clock.
- VELOCITY_RAMP_RESET_InLow, in, 1: asynchronous active-low reset.
- VELOCITY_RAMP_CMDVX_InBus, in, N_WIDTH: commanded vx.
- VELOCITY_RAMP_CMDVY_InBus, in, N_WIDTH: commanded vy.
- VELOCITY_RAMP_CMDWZ_InBus, in, N_WIDTH: commanded wz.
- VELOCITY_RAMP_CMDVALID_InHigh, in, 1: capture the three CMD buses on this edge.
- VELOCITY_RAMP_STOP_InHigh, in, 1: force all commands to zero.
- VELOCITY_RAMP_TARGETVX_OutBus, out, N_WIDTH: ramped vx.
- VELOCITY_RAMP_TARGETVY_OutBus, out, N_WIDTH: ramped vy.
- VELOCITY_RAMP_TARGETWZ_OutBus, out, N_WIDTH: ramped wz.
- VELOCITY_RAMP_SETTLED_OutHigh, out, 1: all three outputs equal their commands.
- VELOCITY_RAMP_UPDATE_OutHigh, out, 1: one-cycle pulse after any step is applied.

Behaviour:
- Single clock domain; reset is asynchronous and active-low.
- Reset values:
  - Command registers, outputs and tick counter = 0.
  - State = IDLE, SETTLED = 1, UPDATE = 0.
  - Reset asserted mid-ramp aborts immediately to these values.
- Command capture:
  - On an edge with CMDVALID=1, all three command registers load the CMD buses.
  - Negative zero (sign 1, magnitude 0) is normalised to +0.
  - STOP=1 loads all commands with 0 and has priority over a simultaneous CMDVALID.
  - A new command accepted during RAMP does not restart the tick counter; the next step heads toward the new command.
- State machine:
  - IDLE: counter held at 0. If any command differs from its output (checked with the post-capture value), go to RAMP with counter = 0. SETTLED drops on the edge of that transition.
  - RAMP: counter increments each cycle. When counter == TICK_DIV-1, counter wraps to 0 and a step is applied on that edge.
  - After a step, go to IDLE if all outputs equal their commands; otherwise stay in RAMP.
  - SETTLED = 1 exactly while in IDLE.
- Latency: for a command captured at edge k from IDLE, the first output change appears after edge k+TICK_DIV+1. Subsequent steps occur every TICK_DIV cycles.
- Step arithmetic, per axis, applied independently:
  - Convert output and command to (N_WIDTH+1)-bit two's complement; diff = cmd - out.
  - If |diff| <= STEP: out = cmd.
  - Otherwise: out = out + STEP*sign(diff).
  - Convert back to sign-magnitude; a zero result is always encoded +0.
  - No overflow is possible because the output only moves toward a representable command, so no saturation logic is needed.
  - Axes with diff = 0 hold their value.
- UPDATE: high for the one cycle following every step edge, even if only one axis changed.
- Outputs are registered; no combinational path from CMD inputs to outputs.

Test Plan:
All cases use TICK_DIV=4, STEP_V=64, STEP_W=16.
1. Reset: assert reset -> all TARGET outputs = 0, SETTLED=1, UPDATE=0. Release and idle 20 cycles -> no change.
2. Ramp up: CMDVX=0_00000001_00000000 (+1.0), CMDVALID one cycle -> TARGETVX = 64, 128, 192, 256 at 4-cycle spacing. First change at k+5. Four UPDATE pulses. SETTLED rises with the 4th step.
3. Zero crossing: from vx=+128, command sign 1 / magnitude 128 -> outputs +64, +0 (sign bit 0), -64, -128. Also command negative zero -> treated as +0.
4. Partial step and mixed axes: vx 0 -> 100 and wz 0 -> 40 together -> vx: 64, 100; wz: 16, 32, 40. SETTLED rises only after the 3rd step.
5. STOP mid-ramp: while ramping vx toward +256 at value 128, assert STOP together with CMDVALID carrying +512 -> command becomes 0, vx ramps 64, 0, then SETTLED=1.
6. Async reset mid-ramp: assert reset between clock edges during RAMP -> outputs clear immediately without a clock edge. After release, no steps occur until a new command arrives.
